// File: rtl/matmul_loader_pkg.sv
// Shared constants, FSM state type and small helpers for the matmul operand loader.
package matmul_loader_pkg;

  localparam int unsigned DWIDTH     = 16;
  localparam int unsigned PACK       = 4;
  localparam int unsigned MAT_SIZE   = 8;
  localparam int unsigned AWIDTH     = 7;
  localparam int unsigned ZERO_ADDR  = 127;
  localparam int unsigned WWIDTH     = DWIDTH * PACK;
  localparam int unsigned NBANK      = MAT_SIZE / PACK;
  localparam int unsigned LANE_W     = $clog2(PACK);
  localparam int unsigned COL_W      = $clog2(MAT_SIZE);
  localparam int unsigned BANK_W     = $clog2(NBANK);
  localparam int unsigned TILE_CNT_W = LANE_W + COL_W;
  localparam int unsigned B_CNT_W    = 2 * COL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_FLUSH_A,
    S_LOAD_B,
    S_ZERO,
    S_START,
    S_WAIT_DONE
  } state_t;

  // One-hot bank write enable from a bank index.
  function automatic logic [NBANK-1:0] bank_onehot(input logic [BANK_W-1:0] idx);
    return NBANK'(1) << idx;
  endfunction

endpackage

// File: rtl/matmul_tile_buffer.sv
// 4x8 element staging buffer for one A bank; a column read returns the packed RAM word.
module matmul_tile_buffer
  import matmul_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [COL_W-1:0]  i_wcol,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [COL_W-1:0]  i_rcol,
  output logic [WWIDTH-1:0] o_rword_c
);

  logic [PACK-1:0][MAT_SIZE-1:0][DWIDTH-1:0] r_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_lane][i_wcol] <= i_wdata;
    end
  end

  // Lane 0 sits in the low bits of the packed word.
  always_comb begin
    o_rword_c = '0;
    for (int l = 0; l < PACK; l++) begin
      o_rword_c[l*DWIDTH +: DWIDTH] = r_mem[LANE_W'(l)][i_rcol];
    end
  end

endmodule

// File: rtl/matmul_operand_loader.sv
// Streams A then B (row-major) into the packed operand banks, writes the pad word,
// kicks off matrix_multiplication and waits for its completion.
module matmul_operand_loader
  import matmul_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WWIDTH-1:0] mem_wdata,
  output logic [NBANK-1:0]  we_a,
  output logic [NBANK-1:0]  we_b,
  output logic              start_mat_mul,
  input  logic              done_mat_mul,
  output logic              busy
);

  localparam logic [TILE_CNT_W-1:0] A_LAST    = '1;
  localparam logic [COL_W-1:0]      COL_LAST  = '1;
  localparam logic [BANK_W-1:0]     BANK_LAST = '1;
  localparam logic [B_CNT_W-1:0]    B_LAST    = '1;
  localparam logic [LANE_W-1:0]     LANE_LAST = '1;

  state_t                          r_state;
  logic                            r_in_ready;
  logic                            r_busy;
  logic [AWIDTH-1:0]               r_addr;
  logic [WWIDTH-1:0]               r_wdata;
  logic [NBANK-1:0]                r_we_a;
  logic [NBANK-1:0]                r_we_b;
  logic                            r_start;
  logic [TILE_CNT_W-1:0]           r_a_cnt;
  logic [BANK_W-1:0]               r_bank;
  logic [COL_W-1:0]                r_col;
  logic [B_CNT_W-1:0]              r_b_cnt;
  logic [PACK-2:0][DWIDTH-1:0]     r_pack;

  logic                            w_accept;
  logic                            w_buf_we;
  logic [WWIDTH-1:0]               w_tile_word;
  logic [LANE_W-1:0]               w_b_lane;
  logic [BANK_W-1:0]               w_b_grp;
  logic [COL_W-1:0]                w_b_row;

  assign w_accept = in_valid & r_in_ready;
  assign w_buf_we = w_accept & (r_state == S_LOAD_A);
  assign w_b_lane = r_b_cnt[LANE_W-1:0];
  assign w_b_grp  = r_b_cnt[LANE_W +: BANK_W];
  assign w_b_row  = r_b_cnt[B_CNT_W-1 -: COL_W];

  matmul_tile_buffer u_tile_buffer (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_buf_we),
    .i_lane    (r_a_cnt[TILE_CNT_W-1 -: LANE_W]),
    .i_wcol    (r_a_cnt[COL_W-1:0]),
    .i_wdata   (in_data),
    .i_rcol    (r_col),
    .o_rword_c (w_tile_word)
  );

  // Control FSM; write strobes and start are single-cycle unless re-asserted by a state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we_a     <= '0;
      r_we_b     <= '0;
      r_start    <= 1'b0;
      r_a_cnt    <= '0;
      r_bank     <= '0;
      r_col      <= '0;
      r_b_cnt    <= '0;
      r_pack     <= '0;
    end else begin
      r_we_a  <= '0;
      r_we_b  <= '0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state    <= S_LOAD_A;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_a_cnt    <= '0;
            r_bank     <= '0;
            r_b_cnt    <= '0;
          end
        end
        S_LOAD_A: begin
          if (w_accept) begin
            r_a_cnt <= r_a_cnt + TILE_CNT_W'(1);
            if (r_a_cnt == A_LAST) begin
              r_state    <= S_FLUSH_A;
              r_in_ready <= 1'b0;
              r_col      <= '0;
            end
          end
        end
        S_FLUSH_A: begin
          r_we_a  <= bank_onehot(r_bank);
          r_addr  <= AWIDTH'(r_col);
          r_wdata <= w_tile_word;
          r_col   <= r_col + COL_W'(1);
          if (r_col == COL_LAST) begin
            r_in_ready <= 1'b1;
            if (r_bank == BANK_LAST) begin
              r_state <= S_LOAD_B;
            end else begin
              r_bank  <= r_bank + BANK_W'(1);
              r_state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_B: begin
          // The final lane bypasses the pack register so the next word can start at once.
          if (w_accept) begin
            r_b_cnt <= r_b_cnt + B_CNT_W'(1);
            if (w_b_lane != LANE_LAST) begin
              r_pack[w_b_lane] <= in_data;
            end else begin
              r_we_b  <= bank_onehot(w_b_grp);
              r_addr  <= AWIDTH'(w_b_row);
              r_wdata <= {in_data, r_pack};
            end
            if (r_b_cnt == B_LAST) begin
              r_state    <= S_ZERO;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_ZERO: begin
          r_addr  <= AWIDTH'(ZERO_ADDR);
          r_wdata <= '0;
          r_we_a  <= '1;
          r_we_b  <= '1;
          r_state <= S_START;
        end
        S_START: begin
          r_start <= 1'b1;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done_mat_mul) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign busy          = r_busy;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign we_a          = r_we_a;
  assign we_b          = r_we_b;
  assign start_mat_mul = r_start;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed bench for matmul_operand_loader: RAM writes are checked against a scoreboard
// built from the bench's own copy of A and B.
module tb_matmul_operand_loader;

  typedef struct packed {
    logic [1:0]  we_a;
    logic [1:0]  we_b;
    logic [6:0]  addr;
    logic [63:0] wdata;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [6:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  we_a;
  logic [1:0]  we_b;
  logic        start_mat_mul;
  logic        done_mat_mul;
  logic        busy;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int zero_cyc  = 0;

  wr_t         sb[$];
  wr_t         wlog[$];
  logic [15:0] ma[8][8];
  logic [15:0] mb[8][8];

  always #5 clk = ~clk;

  matmul_operand_loader dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .we_a          (we_a),
    .we_b          (we_b),
    .start_mat_mul (start_mat_mul),
    .done_mat_mul  (done_mat_mul),
    .busy          (busy)
  );

  task automatic ck(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic [1:0] a, input logic [1:0] b,
                             input logic [6:0] ad, input logic [63:0] d);
    wr_t w;
    w.we_a  = a;
    w.we_b  = b;
    w.addr  = ad;
    w.wdata = d;
    return w;
  endfunction

  function automatic logic [15:0] elem(input int i);
    if (i < 64) return ma[i/8][i%8];
    return mb[(i-64)/8][i%8];
  endfunction

  // Monitor: every RAM write is popped against the scoreboard; start pulses are logged.
  always @(posedge clk) begin
    wr_t got;
    wr_t exp;
    cyc++;
    #1;
    if (we_a != 2'b00 || we_b != 2'b00) begin
      got = mk(we_a, we_b, mem_addr, mem_wdata);
      wlog.push_back(got);
      if (we_a == 2'b11) zero_cyc = cyc;
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      ck("ram_write", 80'(got), 80'(exp));
    end
    if (start_mat_mul) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = 16'($urandom);
        mb[r][c] = 16'($urandom);
      end
  endtask

  task automatic push_expected();
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < 8; c++)
        sb.push_back(mk(2'(1 << h), 2'b00, 7'(c),
                        {ma[4*h+3][c], ma[4*h+2][c], ma[4*h+1][c], ma[4*h][c]}));
    for (int k = 0; k < 8; k++)
      for (int g = 0; g < 2; g++)
        sb.push_back(mk(2'b00, 2'(1 << g), 7'(k),
                        {mb[k][4*g+3], mb[k][4*g+2], mb[k][4*g+1], mb[k][4*g]}));
    sb.push_back(mk(2'b11, 2'b11, 7'd127, 64'd0));
  endtask

  task automatic check_all_zero(input string tag);
    ck({tag, "_we_a"},  80'(we_a), 80'(0));
    ck({tag, "_we_b"},  80'(we_b), 80'(0));
    ck({tag, "_start"}, 80'(start_mat_mul), 80'(0));
    ck({tag, "_busy"},  80'(busy), 80'(0));
    ck({tag, "_ready"}, 80'(in_ready), 80'(0));
    ck({tag, "_addr"},  80'(mem_addr), 80'(0));
    ck({tag, "_wdata"}, 80'(mem_wdata), 80'(0));
  endtask

  // One load: stream 128 elements (optionally toggling in_valid), then hold in WAIT_DONE.
  task automatic do_load(input bit toggle, input int abort_at, input int pulse_at);
    int idx;
    int notready;
    int budget;
    int ls_cyc;
    int s0;
    bit phase;
    bit aborted;
    idx = 0; notready = 0; budget = 0; phase = 1'b0; aborted = 1'b0;
    sb.delete();
    wlog.delete();
    push_expected();
    s0 = start_cnt;
    @(negedge clk);
    load_start = 1'b1;
    ls_cyc = cyc;
    @(negedge clk);
    while (idx < 128 && budget < 2000) begin
      load_start   = (idx == pulse_at);
      done_mat_mul = (idx == pulse_at);
      if (busy && !in_ready) notready++;
      if (toggle && phase) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = elem(idx);
        if (in_ready) idx++;
      end
      phase = !phase;
      budget++;
      if (abort_at > 0 && idx == abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    load_start   = 1'b0;
    done_mat_mul = 1'b0;
    if (aborted) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      check_all_zero("abort_reset");
      sb.delete();
      wlog.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      ck("abort_idle_busy", 80'(busy), 80'(0));
      ck("abort_no_start", 80'(start_cnt - s0), 80'(0));
      return;
    end
    in_valid = 1'b0;
    ck("stream_done", 80'(idx), 80'(128));
    ck("flush_stall_cycles", 80'(notready), 80'(16));
    budget = 0;
    while (start_cnt == s0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    ck("start_seen", 80'(start_cnt - s0), 80'(1));
    // Counted from the load_start cycle through the start_mat_mul cycle, both inclusive.
    if (!toggle) ck("latency", 80'(start_cyc - ls_cyc + 1), 80'(148));
    ck("zero_before_start", 80'(start_cyc - zero_cyc), 80'(1));
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    repeat (4) @(negedge clk);
    ck("busy_wait_done", 80'(busy), 80'(1));
    ck("ready_wait_done", 80'(in_ready), 80'(0));
    ck("single_start", 80'(start_cnt - s0), 80'(1));
    done_mat_mul = 1'b1;
    @(negedge clk);
    done_mat_mul = 1'b0;
    ck("busy_after_done", 80'(busy), 80'(0));
    repeat (3) @(negedge clk);
    ck("idle_stays_idle", 80'(busy), 80'(0));
    ck("queue_drained", 80'(sb.size()), 80'(0));
    ck("write_count", 80'(wlog.size()), 80'(33));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    load_start   = 1'b0;
    in_valid     = 1'b0;
    in_data      = 16'h0;
    done_mat_mul = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ck("idle_busy", 80'(busy), 80'(0));
    ck("idle_ready", 80'(in_ready), 80'(0));

    // Sparse A column and a known B row 0.
    fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) ma[r][c] = 16'h0;
    ma[0][0] = 16'd2; ma[1][0] = 16'd3; ma[2][0] = 16'd5; ma[3][0] = 16'd9;
    mb[0][0] = 16'd1; mb[0][1] = 16'd1; mb[0][2] = 16'd3; mb[0][3] = 16'd3;
    mb[0][4] = 16'd5; mb[0][5] = 16'd1; mb[0][6] = 16'd3; mb[0][7] = 16'd0;
    do_load(1'b0, 0, -1);
    if (wlog.size() == 33) begin
      ck("a00_col0_word", 80'(wlog[0]),  80'(mk(2'b01, 2'b00, 7'd0, 64'h0009_0005_0003_0002)));
      ck("b00_row0_word", 80'(wlog[16]), 80'(mk(2'b00, 2'b01, 7'd0, 64'h0003_0003_0001_0001)));
      ck("b01_row0_word", 80'(wlog[17]), 80'(mk(2'b00, 2'b10, 7'd0, 64'h0000_0003_0001_0005)));
      ck("pad_word",      80'(wlog[32]), 80'(mk(2'b11, 2'b11, 7'd127, 64'd0)));
    end

    // Random full load with stray load_start/done_mat_mul during LOAD_B.
    fill_random();
    do_load(1'b0, 0, 100);

    // Same data with in_valid toggling every cycle.
    do_load(1'b1, 0, -1);

    // Reset mid-A, then a fresh load.
    fill_random();
    do_load(1'b0, 40, -1);
    fill_random();
    do_load(1'b0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
